// File: rtl/button_event_arbiter.sv
// Round-robin serializer of shaped button pulses onto one valid/ready event channel.
// Define BTN_ARB_DROP_CNT_EN to add the saturating drop_cnt counter and port.
module button_event_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
`ifdef BTN_ARB_DROP_CNT_EN
  ,
  parameter int DROP_W  = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_pulse,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic [NUM_REQ-1:0] pending
`ifdef BTN_ARB_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]  drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] clr;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    sel_hi, sel_lo, sel;
  logic               evt_valid_q, evt_valid_d;
  logic               hi_found;
  logic               accept;

  // First set bit above last grant wins; otherwise wrap to lowest set bit.
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_lo = ID_W'(i);
        if (i > int'(last_q)) begin
          sel_hi   = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? sel_hi : sel_lo;
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    last_d      = last_q;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        evt_valid_d = 1'b0;
        if (|pending_q) begin
          evt_id_d    = sel;
          evt_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        evt_valid_d = 1'b1;
        if (evt_ready) begin
          accept      = 1'b1;
          last_d      = evt_id_q;
          evt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      clr[i] = accept && (evt_id_q == ID_W'(i));
    end
  end

  // A new pulse overrides a same-cycle clear so the press becomes a new event.
  assign pending_d = (pending_q & ~clr) | req_pulse;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      last_q      <= last_d;
    end
  end

`ifdef BTN_ARB_DROP_CNT_EN
  logic              coalesce;
  logic [DROP_W-1:0] drop_q, drop_d;

  assign coalesce = |(req_pulse & pending_q & ~clr);

  always_comb begin
    drop_d = drop_q;
    if (coalesce && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects single-cycle button events from several ButtonShaper instances and serializes them onto one event channel for the game-control FSM. Each requester gets a pending latch, so no press is lost while the consumer is busy. A round-robin grant prevents one player or button from starving the others. The block sits between the shaped button inputs and the game logic that consumes one command at a time.

## Interface
- NUM_REQ, 4, number of requesters (shaped button pulses), 2..16
- ID_W, 2, width of event ID; must satisfy 2^ID_W >= NUM_REQ
- DROP_W, 8, width of dropped-event counter (only with macro)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req_pulse  in  NUM_REQ  one-cycle-high event per requester, from ButtonShaper B_out
- evt_valid  out  1  event presented to consumer
- evt_id  out  ID_W  index of requester being served
- evt_ready  in  1  consumer accepts event when high with evt_valid
- pending  out  NUM_REQ  registered pending latches, for debug/LEDs
- drop_cnt  out  DROP_W  saturating count of coalesced (lost) pulses; present only with macro

## Operation
- Pending latch per requester: set on req_pulse[i]; cleared when event i is accepted (evt_valid & evt_ready & evt_id==i).
- Same-cycle set and clear on bit i: the set wins, so pending[i] stays 1 and the new press is a new event.
- Pulse on bit i while pending[i] is already 1 and not being cleared: the pulse is coalesced (no second event). With the macro, drop_cnt increments.
- FSM states:
  - IDLE: evt_valid=0. If any pending bit is set, choose the first set bit, searching upward from (last_grant+1) mod NUM_REQ with wrap. Register it into evt_id and go to PRESENT.
  - PRESENT: evt_valid=1 and evt_id held stable. On evt_ready=1, clear that pending bit, set last_grant=evt_id, and return to IDLE. Otherwise stay.
  - Any illegal state encoding goes to IDLE.
- Selection uses only the registered pending vector. A pulse arriving in the same cycle as the IDLE decision is seen next cycle.
- Outputs evt_valid, evt_id and pending are registered, with no combinational path from inputs.
- Reset values: state=IDLE, pending=0, evt_valid=0, evt_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), drop_cnt=0.

## Timing
- Latency from a pulse in cycle N on an idle block: pending set at N+1, evt_valid=1 at N+2.
- Handshake: transfer occurs in a cycle where evt_valid & evt_ready. evt_valid deasserts the following cycle (IDLE), then the next event appears one cycle later.
- Maximum throughput is one event per 2 cycles.
- evt_ready may be held high continuously. evt_ready while evt_valid=0 is ignored.
- Reset mid-PRESENT: the event is abandoned, all pending bits clear, and evt_valid=0 on the cycle after rst sampled low.
- Requests held off by backpressure accumulate in pending. At most one event per requester is outstanding.

## Configuration
- BTN_ARB_DROP_CNT_EN defined: drop_cnt port and counter exist. The counter increments by exactly 1 per cycle in which at least one pulse is coalesced, saturates at 2^DROP_W-1, and clears only on reset.
- Not defined: no drop_cnt port and no counter logic. Coalescing behaviour is otherwise identical.

## Test plan
- Single press: req_pulse=4'b0100 at cycle 0, evt_ready=1 -> evt_valid=1, evt_id=2 at cycle 2; valid low at cycle 3; pending=0 at cycle 3.
- Simultaneous: req_pulse=4'b0101 after reset, evt_ready=1 -> events id 0 then id 2; second valid at cycle 4.
- Round-robin: keep all 4 requesters re-pulsing every cycle, evt_ready=1 -> evt_id sequence 0,1,2,3,0,1; no ID served twice before the others.
- Backpressure: pulse req 1, evt_ready=0 for 10 cycles -> evt_valid=1, evt_id=1 stable throughout. Raise ready -> accepted; pending[1] clears next cycle.
- Coalesce/drop (macro on): pulse req 3 three times while ready=0 -> one event id 3 only, drop_cnt=2. Same-cycle accept+pulse on req 3 -> pending[3] stays 1 and a second event follows.
- Reset mid-operation: pending=4'b1011 in PRESENT, pull rst low 1 cycle -> next cycle evt_valid=0, pending=0, and the first post-reset event is requester 0.
